run_ctrl: RTL

Parametrised run controller between the bench/board reset and one or more pipelined CPU cores (`top_level` instances). It synchronises reset deassertion and holds each core in reset for a programmable number of cycles. It then runs the cores until every core reports halt or a cycle budget expires, and reports the cycle count and a done/timeout status. It replaces fixed reset-pulse and fixed-run-time sequencing with a synthesizable, restartable sequencer.

---
 rtl/run_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: synchronises reset release, holds cores in reset for RST_CYCLES, then runs
// them until every core has halted or MAX_CYCLES elapse; restartable from DONE via start.
module run_ctrl #(
    parameter int N_CORES    = 1,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 50,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CORES-1:0] halt,
    output logic [N_CORES-1:0] core_rst,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [N_CORES-1:0] halted_mask
);
    localparam int HW = $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_sync;
    logic [HW-1:0]      r_hold;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_CORES-1:0] r_mask;
    logic               r_timeout;
    logic               w_rst_sync, w_hold_end, w_all_halt, w_budget_end;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [N_CORES-1:0] w_mask_or;

    assign w_rst_sync   = r_sync[1];
    assign w_hold_end   = w_rst_sync && (r_hold + 1'b1 == HW'(RST_CYCLES));
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_mask_or    = r_mask | halt;
    assign w_all_halt   = &w_mask_or;
    assign w_budget_end = w_cnt_inc == CNT_W'(MAX_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= HOLD;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HOLD:    w_next = w_hold_end ? RUN : HOLD;
            RUN:     w_next = (w_all_halt || w_budget_end) ? DONE : RUN;
            DONE:    w_next = start ? HOLD : DONE;
            default: w_next = HOLD;
        endcase
    end

    // Halt completion takes priority over the budget, so timeout only flags a pure expiry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold    <= '0;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_rst_sync) r_hold <= w_hold_end ? '0 : r_hold + 1'b1;
                    r_cnt     <= '0;
                    r_mask    <= '0;
                    r_timeout <= 1'b0;
                end
                RUN: begin
                    r_cnt     <= w_cnt_inc;
                    r_mask    <= w_mask_or;
                    r_timeout <= !w_all_halt && w_budget_end;
                end
                DONE: begin
                    if (start) begin
                        r_hold    <= '0;
                        r_cnt     <= '0;
                        r_mask    <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                default: r_hold <= '0;
            endcase
        end
    end

    always_comb begin
        core_rst    = {N_CORES{r_state == HOLD}};
        running     = r_state == RUN;
        done        = r_state == DONE;
        timeout     = r_timeout;
        cycle_count = r_cnt;
        halted_mask = r_mask;
    end
endmodule
